uart_tx_engine: RTL and testbench
=================================

# uart_tx_engine

Serial transmit engine that sits directly downstream of the UART APB register bridge. It consumes the bridge's `send` strobe, transmit byte and line configuration, and serialises one 8N1/8O1/8E1 frame per request onto `tx`. It reports busy and completion status back to the bridge through `tx_active_flag` and `tx_done_flag`. Bit timing comes from an internal baud counter driven by the single system clock.

## Interface

**Parameters**

- `BIT_CYC_0`, default 20833: clock cycles per bit when `baud_rate`=2'b00 (2400 Bd at 50 MHz).
- `BIT_CYC_1`, default 10417: cycles per bit for 2'b01.
- `BIT_CYC_2`, default 5208: cycles per bit for 2'b10.
- `BIT_CYC_3`, default 2604: cycles per bit for 2'b11.
- `CNT_W`, default 16: baud counter width. It must hold max(BIT_CYC_*)−1.

**Ports**

- `PCLK` input 1: system clock; all logic on the rising edge.
- `PRESET` input 1: asynchronous, active-high reset.
- `send` input 1: transmit request from the bridge. A frame starts on its 0→1 edge.
- `DATA_TX` input 8: byte to transmit, sampled at frame acceptance.
- `parity_type` input 2: 00 none, 01 odd, 10 even, 11 none. Sampled at acceptance.
- `baud_rate` input 2: selects `BIT_CYC_n`. Sampled at acceptance.
- `tx_enable` input 1: when low, new requests are ignored. A frame in flight completes.
- `tx` output 1: serial line, idle high.
- `tx_active_flag` output 1: high while a frame is on the line.
- `tx_done_flag` output 1: high from end of stop bit until the next accepted frame.

## Operation

**Reset values**

- `tx`=1, `tx_active_flag`=0, `tx_done_flag`=0.
- State IDLE, counters 0, `send_q`=0.

**Request detection**

- `send_q` registers `send` each cycle.
- A request is accepted when `send & ~send_q & tx_enable` and the state is IDLE.
- Because detection is edge-based, a `send` level held high across `tx_done_flag` never retransmits.

**On acceptance**

- Latch the shift register, parity mode and bit period.
- Compute the parity bit:
  - odd: ~^DATA_TX
  - even: ^DATA_TX
- Clear `tx_done_flag`, set `tx_active_flag`, go to START.

**State machine** (each state lasts one bit period of P = latched BIT_CYC cycles)

- IDLE: `tx`=1.
- START: `tx`=0.
- DATA: 8 bits, LSB first; a bit index counts 0..7, then leaves DATA.
- PARITY: `tx`=parity bit. Entered only if the latched mode is 01 or 10; otherwise DATA goes straight to STOP.
- STOP: `tx`=1. At the end of STOP:
  - go to IDLE;
  - `tx_active_flag`←0;
  - `tx_done_flag`←1.

**Baud counter**

- Counts 0..P−1 within a bit.
- A wrap advances the bit or state.
- The counter is reset to 0 at every state entry.

**Boundary conditions**

- `send` edge while not IDLE: ignored, not queued.
- `DATA_TX`, `parity_type` or `baud_rate` changing mid-frame: no effect on the current frame.
- `tx_enable` dropping mid-frame: the frame still completes.
- `PRESET` mid-frame: `tx` goes high immediately (asynchronously), the FSM goes to IDLE, both flags go to 0, and no done is reported.
- A `send` edge in the same cycle the FSM returns to IDLE (STOP wrap): ignored. It must arrive at least one cycle after `tx_done_flag` rises.

## Timing

- Edge-detect latency: the edge is sampled on cycle N (`send`=1, `send_q`=0), the FSM enters START on edge N+1, and `tx` falls on that same edge.
- In the same N+1 edge, `tx_active_flag` goes to 1 and `tx_done_flag` goes to 0.
- Frame length: (10 + p)·P cycles, where p=1 if parity is enabled, else 0.
- `tx_done_flag` rises at edge N+1+(10+p)·P. It rises in the same cycle `tx_active_flag` falls and STOP ends.
- Minimum request spacing: one frame plus one idle cycle.
- All outputs are registered; no combinational path from input to output.

## Test plan

Bench parameters for all scenarios: `BIT_CYC_0..3` = 4, 8, 16, 32.

1. **Reset then idle.** Assert `PRESET` for 3 cycles, then release; hold `send`=0 for 50 cycles → `tx`=1 and both flags 0 throughout.
2. **8N1 frame.** `DATA_TX`=8'hA5, `parity_type`=00, `baud_rate`=00, `tx_enable`=1, pulse `send` → `tx` pattern 0,1,0,1,0,0,1,0,1,1, each level held 4 cycles. `tx_done_flag` rises exactly 41 cycles after the edge cycle.
3. **Odd and even parity.**
   - `DATA_TX`=8'h07, `parity_type`=01, `baud_rate`=01 → parity bit 0, frame 88 cycles.
   - Same byte with `parity_type`=10 → parity bit 1.
4. **Held send and busy request.**
   - Hold `send`=1 through `tx_done_flag` → exactly one frame is sent.
   - A second edge mid-frame is ignored, and `DATA_TX` changed mid-frame does not alter the bits on the line.
5. **Enable gating.** `tx_enable`=0 with a `send` edge → no frame and flags unchanged. Drop `tx_enable` mid-frame → the frame completes and `tx_done_flag`=1.
6. **Reset mid-frame.** Assert `PRESET` during data bit 3 → `tx`=1 in the same cycle and both flags 0. After release, a new `send` edge with 8'h3C transmits a correct frame.

Source files
------------

// File: rtl/uart_tx_engine.sv
// UART transmit engine: edge-triggered request, 8-bit LSB-first frame with optional
// odd/even parity, one stop bit; bit period selected per frame from four baud settings.
module uart_tx_engine #(
   parameter int BIT_CYC_0 = 20833,
   parameter int BIT_CYC_1 = 10417,
   parameter int BIT_CYC_2 = 5208,
   parameter int BIT_CYC_3 = 2604,
   parameter int CNT_W     = 16
) (
   input  logic       PCLK,
   input  logic       PRESET,
   input  logic       send,
   input  logic [7:0] DATA_TX,
   input  logic [1:0] parity_type,
   input  logic [1:0] baud_rate,
   input  logic       tx_enable,
   output logic       tx,
   output logic       tx_active_flag,
   output logic       tx_done_flag,
   output logic [2:0] fsm_state
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       bit_q, bit_d;
   logic [7:0]       data_q;
   logic             par_q;
   logic             par_en_q;
   logic [CNT_W-1:0] period_q;
   logic             send_q;
   logic             accept;
   logic             wrap;
   logic             tx_d;
   logic             active_d;
   logic             done_d;

   assign accept    = (state_q == IDLE) & send & ~send_q & tx_enable;
   assign wrap      = (cnt_q == period_q - CNT_W'(1));
   assign fsm_state = state_q;

   // State register and frame counters.
   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         send_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         send_q  <= send;
      end
   end

   // Frame parameters are frozen at acceptance so bridge-side changes cannot disturb a frame.
   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         data_q   <= '0;
         par_q    <= 1'b0;
         par_en_q <= 1'b0;
         period_q <= '0;
      end else if (accept) begin
         data_q   <= DATA_TX;
         par_q    <= (parity_type == 2'b01) ? ~^DATA_TX : ^DATA_TX;
         par_en_q <= (parity_type == 2'b01) || (parity_type == 2'b10);
         case (baud_rate)
            2'b00:   period_q <= CNT_W'(BIT_CYC_0);
            2'b01:   period_q <= CNT_W'(BIT_CYC_1);
            2'b10:   period_q <= CNT_W'(BIT_CYC_2);
            default: period_q <= CNT_W'(BIT_CYC_3);
         endcase
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + CNT_W'(1);
      bit_d   = bit_q;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (accept) state_d = START;
         end
         START: begin
            if (wrap) begin
               state_d = DATA;
               cnt_d   = '0;
               bit_d   = '0;
            end
         end
         DATA: begin
            if (wrap) begin
               cnt_d = '0;
               if (bit_q == 3'd7) state_d = par_en_q ? PARITY : STOP;
               else               bit_d   = bit_q + 3'd1;
            end
         end
         PARITY: begin
            if (wrap) begin
               state_d = STOP;
               cnt_d   = '0;
            end
         end
         STOP: begin
            if (wrap) begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Outputs are decoded from the next state and registered, so tx changes on the entry edge.
   always_comb begin
      tx_d     = 1'b1;
      active_d = (state_d != IDLE);
      done_d   = tx_done_flag;
      case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = data_q[bit_d];
         PARITY:  tx_d = par_q;
         default: tx_d = 1'b1;
      endcase
      if (accept)                          done_d = 1'b0;
      else if ((state_q == STOP) && wrap)  done_d = 1'b1;
   end

   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         tx             <= 1'b1;
         tx_active_flag <= 1'b0;
         tx_done_flag   <= 1'b0;
      end else begin
         tx             <= tx_d;
         tx_active_flag <= active_d;
         tx_done_flag   <= done_d;
      end
   end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Self-checking bench for uart_tx_engine: table vectors, random frames against a
// frame-level reference model, and hand-written reset/enable sequences.
module tb_uart_tx_engine;

   localparam int P0 = 4;
   localparam int P1 = 8;
   localparam int P2 = 16;
   localparam int P3 = 32;

   logic       clk;
   logic       rst;
   logic       send;
   logic [7:0] data_tx;
   logic [1:0] parity_type;
   logic [1:0] baud_rate;
   logic       tx_enable;
   logic       tx;
   logic       tx_active_flag;
   logic       tx_done_flag;
   logic [2:0] fsm_state;

   int n_checks = 0;
   int n_bad    = 0;

   typedef struct {
      logic [7:0] data;
      logic [1:0] pt;
      logic [1:0] baud;
      int         mode;     // 0 pulse, 1 hold send, 2 busy edge + input churn, 3 drop enable
      int         exp_len;
      logic       exp_par;
   } vec_t;

   vec_t vecs[6];

   uart_tx_engine #(
      .BIT_CYC_0(P0), .BIT_CYC_1(P1), .BIT_CYC_2(P2), .BIT_CYC_3(P3), .CNT_W(16)
   ) dut (
      .PCLK(clk), .PRESET(rst), .send(send), .DATA_TX(data_tx),
      .parity_type(parity_type), .baud_rate(baud_rate), .tx_enable(tx_enable),
      .tx(tx), .tx_active_flag(tx_active_flag), .tx_done_flag(tx_done_flag),
      .fsm_state(fsm_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic int period_of(input logic [1:0] b);
      case (b)
         2'b00:   return P0;
         2'b01:   return P1;
         2'b10:   return P2;
         default: return P3;
      endcase
   endfunction

   function automatic bit has_par(input logic [1:0] pt);
      return (pt == 2'b01) || (pt == 2'b10);
   endfunction

   function automatic int frame_bits(input logic [1:0] pt);
      return has_par(pt) ? 11 : 10;
   endfunction

   // Line level for bit slot idx of the frame: start, 8 data LSB first, optional parity, stop.
   function automatic logic level_at(input logic [7:0] d, input logic [1:0] pt, input int idx);
      int ones;
      ones = $countones(d);
      if (idx == 0) return 1'b0;
      if (idx <= 8) return d[idx-1];
      if (has_par(pt) && idx == 9) begin
         if (pt == 2'b01) return (ones % 2 == 0);
         return (ones % 2 == 1);
      end
      return 1'b1;
   endfunction

   task automatic run_frame(input logic [7:0] d, input logic [1:0] pt, input logic [1:0] b,
                            input int mode, output int act_cnt, output logic par_seen);
      int p;
      int l;
      int bad_tx;
      int bad_flags;
      int bad_idle;
      p = period_of(b);
      l = frame_bits(pt) * p;
      @(posedge clk); #1;
      send      = 1'b0;
      tx_enable = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      data_tx     = d;
      parity_type = pt;
      baud_rate   = b;
      send        = 1'b1;
      act_cnt   = 0;
      par_seen  = 1'bx;
      bad_tx    = 0;
      bad_flags = 0;
      for (int k = 0; k < l; k++) begin
         @(posedge clk); #1;
         if (mode != 1 && k == 0) send = 1'b0;
         if (mode == 2 && k == l / 2) begin
            send        = 1'b1;
            data_tx     = ~d;
            parity_type = ~pt;
            baud_rate   = b + 2'd1;
         end
         if (mode == 3 && k == l / 2) tx_enable = 1'b0;
         @(negedge clk);
         if (tx !== level_at(d, pt, k / p)) bad_tx++;
         if (tx_active_flag === 1'b1) act_cnt++;
         if (tx_done_flag !== 1'b0) bad_flags++;
         if (has_par(pt) && k == 9 * p + p / 2) par_seen = tx;
         if (k % p == p - 1) begin
            check($sformatf("tx_bit%0d_data%0h", k / p, d), bad_tx, 0);
            bad_tx = 0;
         end
      end
      check("done_low_in_frame", bad_flags, 0);
      @(posedge clk);
      @(negedge clk);
      check("done_rise", tx_done_flag, 1);
      check("active_fall", tx_active_flag, 0);
      check("tx_after_stop", tx, 1);
      tx_enable = 1'b1;
      bad_idle = 0;
      repeat (2 * p) begin
         @(negedge clk);
         if (tx !== 1'b1 || tx_active_flag !== 1'b0 || tx_done_flag !== 1'b1) bad_idle++;
      end
      check("post_frame_idle", bad_idle, 0);
   endtask

   initial begin
      int   act;
      logic par;
      int   bad;
      logic [7:0] rd;
      logic [1:0] rpt;
      logic [1:0] rb;

      vecs[0] = '{8'hA5, 2'b00, 2'b00, 0, 40,  1'b0};
      vecs[1] = '{8'h07, 2'b01, 2'b01, 0, 88,  1'b0};
      vecs[2] = '{8'h07, 2'b10, 2'b01, 0, 88,  1'b1};
      vecs[3] = '{8'hC3, 2'b11, 2'b00, 1, 40,  1'b0};
      vecs[4] = '{8'h5A, 2'b10, 2'b10, 2, 176, 1'b0};
      vecs[5] = '{8'hF0, 2'b01, 2'b00, 3, 44,  1'b1};

      rst = 1'b1; send = 1'b0; data_tx = '0; parity_type = '0; baud_rate = '0; tx_enable = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_tx", tx, 1);
      check("reset_active", tx_active_flag, 0);
      check("reset_done", tx_done_flag, 0);
      #1 rst = 1'b0;
      bad = 0;
      repeat (50) begin
         @(negedge clk);
         if (tx !== 1'b1 || tx_active_flag !== 1'b0 || tx_done_flag !== 1'b0) bad++;
      end
      check("idle_after_reset", bad, 0);

      for (int i = 0; i < 6; i++) begin
         run_frame(vecs[i].data, vecs[i].pt, vecs[i].baud, vecs[i].mode, act, par);
         check($sformatf("vec%0d_frame_len", i), act, vecs[i].exp_len);
         if (has_par(vecs[i].pt)) check($sformatf("vec%0d_parity", i), par, vecs[i].exp_par);
      end

      // Request with enable low: nothing starts and the done flag from the last frame stays.
      @(posedge clk); #1;
      tx_enable = 1'b0;
      send      = 1'b0;
      @(posedge clk); #1;
      send = 1'b1;
      bad  = 0;
      repeat (20) begin
         @(negedge clk);
         if (tx !== 1'b1 || tx_active_flag !== 1'b0 || tx_done_flag !== 1'b1) bad++;
      end
      check("enable_low_ignored", bad, 0);
      send      = 1'b0;
      tx_enable = 1'b1;

      for (int i = 0; i < 8; i++) begin
         rd  = 8'($urandom_range(0, 255));
         rpt = 2'($urandom_range(0, 3));
         rb  = 2'($urandom_range(0, 2));
         run_frame(rd, rpt, rb, 0, act, par);
         check($sformatf("rand%0d_frame_len", i), act, frame_bits(rpt) * period_of(rb));
      end

      // Reset during data bit 3 of an all-zero byte: the line must jump high at once.
      @(posedge clk); #1;
      send = 1'b0;
      @(posedge clk); #1;
      data_tx = 8'h00; parity_type = 2'b00; baud_rate = 2'b00; send = 1'b1;
      for (int k = 0; k <= 17; k++) begin
         @(posedge clk); #1;
         if (k == 0) send = 1'b0;
      end
      @(negedge clk);
      check("pre_reset_tx_low", tx, 0);
      check("pre_reset_active", tx_active_flag, 1);
      @(posedge clk); #2;
      rst = 1'b1;
      #1;
      check("midframe_reset_tx", tx, 1);
      check("midframe_reset_active", tx_active_flag, 0);
      check("midframe_reset_done", tx_done_flag, 0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
      bad = 0;
      repeat (10) begin
         @(negedge clk);
         if (tx !== 1'b1 || tx_active_flag !== 1'b0 || tx_done_flag !== 1'b0) bad++;
      end
      check("idle_after_midframe_reset", bad, 0);
      run_frame(8'h3C, 2'b00, 2'b00, 0, act, par);
      check("after_reset_frame_len", act, 40);

      $display("test done: total=%0d bad=%0d", n_checks, n_bad);
      $finish;
   end

endmodule
